// File: rtl/mpmc11_port_arbiter_if.sv
// Request/grant bundle between mpmc11 requester ports, the command controller and the arbiter.
// The master side drives requests and controller pulses; the slave side is the arbiter.
interface mpmc11_port_arbiter_if #(
  parameter int NPORT = 16,
  parameter int PORTW = 4
) ();
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] lock;
  logic             cmd_ack;
  logic             done;
  logic             gnt_valid;
  logic [PORTW-1:0] gnt_port;
  logic [NPORT-1:0] gnt_onehot;
  logic             busy;

  modport master (
    output req, lock, cmd_ack, done,
    input  gnt_valid, gnt_port, gnt_onehot, busy
  );

  modport slave (
    input  req, lock, cmd_ack, done,
    output gnt_valid, gnt_port, gnt_onehot, busy
  );
endinterface

// File: rtl/mpmc11_port_arbiter.sv
// Round-robin arbiter for the mpmc11 command path: grants one port at a time, holds it
// through command acceptance and completion, and allows bounded bursts for locked ports.
//
// state        | meaning
// ST_IDLE      | no owner; scan req from last+1 and grant the first hit
// ST_GRANT     | grant presented, waiting for cmd_ack (or withdrawal of req)
// ST_WAIT_DONE | command accepted, waiting for the transaction to finish
module mpmc11_port_arbiter #(
  parameter int NPORT     = 16,
  parameter int PORTW     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mpmc11_port_arbiter_if.slave arb
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PORTW-1:0] last_q, last_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [PORTW-1:0] gnt_port_q, gnt_port_d;
  logic [NPORT-1:0] gnt_onehot_q, gnt_onehot_d;
  logic             busy_q, busy_d;

  logic             win_found;
  logic [PORTW-1:0] win_port;
  logic [PORTW-1:0] cand;
  logic             finish;
  logic             rearm;

  // Rotating priority scan; candidates are reduced modulo NPORT so no port >= NPORT is produced.
  always_comb begin
    win_found = 1'b0;
    win_port  = '0;
    cand      = '0;
    for (int i = 1; i <= NPORT; i++) begin
      cand = PORTW'((int'(last_q) + i) % NPORT);
      if (!win_found && arb.req[cand]) begin
        win_found = 1'b1;
        win_port  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    burst_cnt_d  = burst_cnt_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_port_d   = gnt_port_q;
    gnt_onehot_d = gnt_onehot_q;
    busy_d       = busy_q;
    finish       = 1'b0;
    rearm        = arb.lock[gnt_port_q] && arb.req[gnt_port_q] &&
                   (burst_cnt_q < 8'(MAX_BURST - 1));

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d                = ST_GRANT;
          gnt_port_d             = win_port;
          gnt_onehot_d           = '0;
          gnt_onehot_d[win_port] = 1'b1;
          gnt_valid_d            = 1'b1;
          busy_d                 = 1'b1;
        end
      end
      ST_GRANT: begin
        if (arb.cmd_ack && arb.done) begin
          finish = 1'b1;
        end else if (arb.cmd_ack) begin
          state_d     = ST_WAIT_DONE;
          gnt_valid_d = 1'b0;
        end else if (!arb.req[gnt_port_q]) begin
          state_d      = ST_IDLE;
          last_d       = gnt_port_q;
          gnt_valid_d  = 1'b0;
          gnt_onehot_d = '0;
          busy_d       = 1'b0;
          burst_cnt_d  = '0;
        end
      end
      ST_WAIT_DONE: begin
        if (arb.done) finish = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Transaction complete: either re-grant the locked port or release the path.
    if (finish) begin
      if (rearm) begin
        state_d     = ST_GRANT;
        burst_cnt_d = burst_cnt_q + 8'd1;
        gnt_valid_d = 1'b1;
      end else begin
        state_d      = ST_IDLE;
        last_d       = gnt_port_q;
        burst_cnt_d  = '0;
        gnt_valid_d  = 1'b0;
        gnt_onehot_d = '0;
        busy_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= PORTW'(NPORT - 1);
      burst_cnt_q  <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_port_q   <= '0;
      gnt_onehot_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      burst_cnt_q  <= burst_cnt_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_port_q   <= gnt_port_d;
      gnt_onehot_q <= gnt_onehot_d;
      busy_q       <= busy_d;
    end
  end

  assign arb.gnt_valid  = gnt_valid_q;
  assign arb.gnt_port   = gnt_port_q;
  assign arb.gnt_onehot = gnt_onehot_q;
  assign arb.busy       = busy_q;

endmodule

// File: tb/tb_mpmc11_port_arbiter.sv
// Directed bench for mpmc11_port_arbiter: single grant, full round-robin sweep, locked bursts,
// request withdrawal, same-cycle ack/done and reset during a burst.
module tb_mpmc11_port_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mpmc11_port_arbiter_if #(.NPORT(16), .PORTW(4)) arb_if ();

  mpmc11_port_arbiter #(.NPORT(16), .PORTW(4), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_grant(input string tag, input int port);
    chk({tag, "_valid"},  32'(arb_if.gnt_valid), 32'd1);
    chk({tag, "_port"},   32'(arb_if.gnt_port), 32'(port));
    chk({tag, "_onehot"}, 32'(arb_if.gnt_onehot), 32'(1) << port);
    chk({tag, "_busy"},   32'(arb_if.busy), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"},  32'(arb_if.gnt_valid), 32'd0);
    chk({tag, "_onehot"}, 32'(arb_if.gnt_onehot), 32'd0);
    chk({tag, "_busy"},   32'(arb_if.busy), 32'd0);
  endtask

  task automatic ack_then_done();
    arb_if.cmd_ack = 1'b1;
    tick();
    arb_if.cmd_ack = 1'b0;
    chk("wait_valid", 32'(arb_if.gnt_valid), 32'd0);
    chk("wait_busy",  32'(arb_if.busy), 32'd1);
    arb_if.done = 1'b1;
    tick();
    arb_if.done = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst            = 1'b1;
    arb_if.req     = '0;
    arb_if.lock    = '0;
    arb_if.cmd_ack = 1'b0;
    arb_if.done    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid",  32'(arb_if.gnt_valid), 32'd0);
    chk("rst_port",   32'(arb_if.gnt_port), 32'd0);
    chk("rst_onehot", 32'(arb_if.gnt_onehot), 32'd0);
    chk("rst_busy",   32'(arb_if.busy), 32'd0);

    // Single request from port 5; completion frees the path and leaves last=5.
    arb_if.req = 16'h0020;
    tick();
    chk_grant("p5", 5);
    arb_if.cmd_ack = 1'b1;
    tick();
    arb_if.cmd_ack = 1'b0;
    arb_if.req     = '0;
    chk("p5_ack_valid", 32'(arb_if.gnt_valid), 32'd0);
    chk("p5_ack_port",  32'(arb_if.gnt_port), 32'd5);
    chk("p5_ack_busy",  32'(arb_if.busy), 32'd1);
    arb_if.done = 1'b1;
    tick();
    arb_if.done = 1'b0;
    chk_idle("p5_done");
    chk("p5_done_port", 32'(arb_if.gnt_port), 32'd5);
    arb_if.req = 16'hFFFF;
    tick();
    chk_grant("after_last5", 6);

    // Full sweep from reset: 0..15 then wrap to 0, one IDLE cycle between grants.
    arb_if.req = '0;
    do_reset();
    arb_if.req = 16'hFFFF;
    tick();
    for (int k = 0; k <= 16; k++) begin
      chk_grant("rr", k % 16);
      ack_then_done();
      chk_idle("rr_gap");
      if (k < 16) tick();
    end

    // Locked port 3: four back-to-back grants, then port 7, then port 3 again.
    arb_if.req = '0;
    do_reset();
    arb_if.req  = 16'h0088;
    arb_if.lock = 16'h0008;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk_grant("burst3", 3);
      ack_then_done();
    end
    chk_idle("burst_end");
    tick();
    chk_grant("after_burst7", 7);
    ack_then_done();
    chk_idle("p7_done");
    tick();
    chk_grant("back_to3", 3);

    // Port 9 withdraws before cmd_ack; port 10 is next.
    arb_if.req  = '0;
    arb_if.lock = '0;
    do_reset();
    arb_if.req = 16'h0600;
    tick();
    chk_grant("p9", 9);
    arb_if.req = 16'h0400;
    tick();
    chk_idle("withdraw");
    tick();
    chk_grant("p10", 10);

    // cmd_ack and done together: release when unlocked, immediate regrant when locked.
    arb_if.req = '0;
    do_reset();
    arb_if.req = 16'h0001;
    tick();
    chk_grant("p0", 0);
    arb_if.cmd_ack = 1'b1;
    arb_if.done    = 1'b1;
    tick();
    arb_if.cmd_ack = 1'b0;
    arb_if.done    = 1'b0;
    chk_idle("ackdone_free");
    arb_if.req  = 16'h0002;
    arb_if.lock = 16'h0002;
    tick();
    chk_grant("p1", 1);
    arb_if.cmd_ack = 1'b1;
    arb_if.done    = 1'b1;
    tick();
    arb_if.cmd_ack = 1'b0;
    arb_if.done    = 1'b0;
    chk_grant("ackdone_regrant", 1);

    // Reset while in WAIT_DONE mid-burst; afterwards the scan restarts at port 0.
    arb_if.cmd_ack = 1'b1;
    tick();
    arb_if.cmd_ack = 1'b0;
    chk("burst_wait_busy", 32'(arb_if.busy), 32'd1);
    rst         = 1'b1;
    arb_if.req  = 16'h000C;
    arb_if.lock = '0;
    tick();
    rst = 1'b0;
    chk_idle("rst_mid");
    chk("rst_mid_port", 32'(arb_if.gnt_port), 32'd0);
    tick();
    chk_grant("post_rst", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
